// File: rtl/hud_controller_if.sv
// Game-logic side of the HUD sequencer: event inputs in, registered HUD values out.
interface hud_controller_if;
    logic start;
    logic pause;
    logic hit;
    logic frame_start;
    int   number;
    int   lives;
    logic show_hearts;
    logic invulnerable;
    logic game_over;
    logic time_up;

    modport master (
        output start, pause, hit, frame_start,
        input  number, lives, show_hearts, invulnerable, game_over, time_up
    );

    modport slave (
        input  start, pause, hit, frame_start,
        output number, lives, show_hearts, invulnerable, game_over, time_up
    );
endinterface

// File: rtl/hud_controller.sv
// Countdown clock, life counter and post-hit heart blinking for the VGA HUD drawer.
module hud_controller #(
    parameter int unsigned CLK_HZ        = 25_000_000,
    parameter int unsigned START_TIME    = 29,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned BLINK_FRAMES  = 8,
    parameter int unsigned INVULN_FRAMES = 96
) (
    input logic             clk,
    input logic             reset,
    hud_controller_if.slave bus
);
    localparam int unsigned PresW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned FrameW = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PresW-1:0]  PresLast  = PresW'(CLK_HZ - 1);
    localparam logic [FrameW-1:0] FrameLast = FrameW'(INVULN_FRAMES - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StInvuln, StOver} state_e;

    state_e            state_q, state_d;
    logic [PresW-1:0]  presc_q, presc_d;
    logic [FrameW-1:0] frame_q, frame_d;
    logic [BlinkW-1:0] blink_q, blink_d;
    int                number_q, number_d;
    int                lives_q, lives_d;
    logic              phase_q, phase_d;
    logic              show_q, show_d;
    logic              inv_q, over_q;
    logic              time_up_q, time_up_d;

    logic active, wrap, hit_ok;

    // Timing only advances in the playing states and never while paused.
    assign active = (state_q == StRun || state_q == StInvuln) && !bus.pause;
    assign wrap   = active && (presc_q == PresLast);
    assign hit_ok = active && (state_q == StRun) && bus.hit;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        frame_d   = frame_q;
        blink_d   = blink_q;
        number_d  = number_q;
        lives_d   = lives_q;
        phase_d   = phase_q;
        time_up_d = time_up_q;

        if (bus.start) begin
            state_d   = StRun;
            presc_d   = '0;
            frame_d   = '0;
            blink_d   = '0;
            number_d  = int'(START_TIME);
            lives_d   = int'(START_LIVES);
            phase_d   = 1'b1;
            time_up_d = 1'b0;
        end else if (active) begin
            presc_d = wrap ? '0 : presc_q + PresW'(1);
            if (wrap && number_q > 0) begin
                number_d = number_q - 1;
            end
            if (hit_ok && lives_q > 0) begin
                lives_d = lives_q - 1;
                state_d = StInvuln;
                frame_d = '0;
                blink_d = '0;
                phase_d = 1'b0;
            end else if (state_q == StInvuln && bus.frame_start) begin
                frame_d = frame_q + FrameW'(1);
                if (frame_q == FrameLast) begin
                    state_d = StRun;
                end
                if (blink_q == BlinkLast) begin
                    blink_d = '0;
                    phase_d = !phase_q;
                end else begin
                    blink_d = blink_q + BlinkW'(1);
                end
            end
            if (number_d == 0 || lives_d == 0) begin
                state_d   = StOver;
                time_up_d = (number_d == 0);
            end
        end

        // Hearts stay solid outside invulnerability and while paused; phase is kept underneath.
        show_d = (state_d == StInvuln && !bus.pause) ? phase_d : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            frame_q   <= '0;
            blink_q   <= '0;
            number_q  <= int'(START_TIME);
            lives_q   <= int'(START_LIVES);
            phase_q   <= 1'b1;
            show_q    <= 1'b1;
            inv_q     <= 1'b0;
            over_q    <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            frame_q   <= frame_d;
            blink_q   <= blink_d;
            number_q  <= number_d;
            lives_q   <= lives_d;
            phase_q   <= phase_d;
            show_q    <= show_d;
            inv_q     <= (state_d == StInvuln);
            over_q    <= (state_d == StOver);
            time_up_q <= time_up_d;
        end
    end

    assign bus.number       = number_q;
    assign bus.lives        = lives_q;
    assign bus.show_hearts  = show_q;
    assign bus.invulnerable = inv_q;
    assign bus.game_over    = over_q;
    assign bus.time_up      = time_up_q;
endmodule

// File: tb/tb_hud_controller.sv
// Directed bench: a fast instance for countdown/blink/pause/reset, a slower one for life loss.
module tb_hud_controller;
    logic clk = 1'b0;
    logic reset;
    logic start, pause, hit, frame_start;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hud_controller_if bus_f ();
    hud_controller_if bus_s ();

    assign bus_f.start       = start;
    assign bus_f.pause       = pause;
    assign bus_f.hit         = hit;
    assign bus_f.frame_start = frame_start;
    assign bus_s.start       = start;
    assign bus_s.pause       = pause;
    assign bus_s.hit         = hit;
    assign bus_s.frame_start = frame_start;

    hud_controller #(
        .CLK_HZ(4), .START_TIME(3), .START_LIVES(3), .BLINK_FRAMES(2), .INVULN_FRAMES(6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_f)
    );

    // Slower countdown so three full invulnerability periods fit before time runs out.
    hud_controller #(
        .CLK_HZ(16), .START_TIME(3), .START_LIVES(3), .BLINK_FRAMES(2), .INVULN_FRAMES(6)
    ) dut_slow (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_s)
    );

    typedef struct packed {
        logic s, p, h, f;
        int   num;
        int   liv;
        logic show, inv, over, tu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, p, h, f, input int num, liv,
                                input logic show, inv, over, tu);
        vec_t v;
        v.s = s; v.p = p; v.h = h; v.f = f;
        v.num = num; v.liv = liv;
        v.show = show; v.inv = inv; v.over = over; v.tu = tu;
        return v;
    endfunction

    task automatic cyc(input logic s, p, h, f);
        start = s; pause = p; hit = h; frame_start = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input bit slow, input int num, liv,
                         input logic show, inv, over, tu);
        int   a_num, a_liv;
        logic a_show, a_inv, a_over, a_tu;
        if (slow) begin
            a_num = bus_s.number; a_liv = bus_s.lives; a_show = bus_s.show_hearts;
            a_inv = bus_s.invulnerable; a_over = bus_s.game_over; a_tu = bus_s.time_up;
        end else begin
            a_num = bus_f.number; a_liv = bus_f.lives; a_show = bus_f.show_hearts;
            a_inv = bus_f.invulnerable; a_over = bus_f.game_over; a_tu = bus_f.time_up;
        end
        vectors++;
        if (a_num !== num || a_liv !== liv || a_show !== show || a_inv !== inv ||
            a_over !== over || a_tu !== tu) begin
            miscompares++;
            $display("FAIL %s: got number=%0d lives=%0d show=%b inv=%b over=%b time_up=%b, want number=%0d lives=%0d show=%b inv=%b over=%b time_up=%b",
                     name, a_num, a_liv, a_show, a_inv, a_over, a_tu,
                     num, liv, show, inv, over, tu);
        end
    endtask

    initial begin
        // Countdown from IDLE to time-up, then a hit-driven invulnerability period.
        vecs.push_back(mk(1, 0, 0, 0, 3, 3, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 3, 3, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 2, 3, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 3, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 3, 3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3, 2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 3, 2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 2, 2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2, 1, 0, 0, 0));

        reset = 1'b1;
        start = 1'b0; pause = 1'b0; hit = 1'b0; frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset", 0, 3, 3, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].s, vecs[i].p, vecs[i].h, vecs[i].f);
            check($sformatf("vec%0d", i), 0, vecs[i].num, vecs[i].liv,
                  vecs[i].show, vecs[i].inv, vecs[i].over, vecs[i].tu);
        end

        // Pause mid-count and mid-invulnerability; hits and frames must be ignored.
        cyc(1, 0, 0, 0); check("p_start", 0, 3, 3, 1, 0, 0, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 1, 0); check("p_run_hold", 0, 3, 3, 1, 0, 0, 0);
        end
        cyc(0, 0, 0, 0); check("p_run_resume", 0, 3, 3, 1, 0, 0, 0);
        cyc(0, 0, 0, 0); check("p_run_wrap", 0, 2, 3, 1, 0, 0, 0);
        cyc(0, 0, 1, 0); check("p_hit", 0, 2, 2, 0, 1, 0, 0);
        cyc(0, 0, 0, 1); check("p_frame1", 0, 2, 2, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 1, 1); check("p_inv_hold", 0, 2, 2, 1, 1, 0, 0);
        end
        cyc(0, 0, 0, 0); check("p_inv_phase", 0, 2, 2, 0, 1, 0, 0);
        cyc(0, 0, 0, 1); check("p_frame2", 0, 1, 2, 1, 1, 0, 0);
        cyc(0, 0, 0, 1); check("p_frame3", 0, 1, 2, 1, 1, 0, 0);
        cyc(0, 0, 0, 1); check("p_frame4", 0, 1, 2, 0, 1, 0, 0);
        cyc(0, 0, 0, 1); check("p_frame5", 0, 1, 2, 0, 1, 0, 0);
        cyc(0, 0, 0, 1); check("p_frame6_timeout", 0, 0, 2, 1, 0, 1, 1);

        // Lives exhausted by three hits, one per invulnerability period.
        cyc(1, 0, 0, 0); check("l_start", 1, 3, 3, 1, 0, 0, 0);
        cyc(0, 0, 1, 0); check("l_hit1", 1, 3, 2, 0, 1, 0, 0);
        cyc(0, 0, 1, 1); check("l_hit_inv", 1, 3, 2, 0, 1, 0, 0);
        repeat (5) cyc(0, 0, 0, 1);
        check("l_inv1_end", 1, 3, 2, 1, 0, 0, 0);
        cyc(0, 0, 1, 0); check("l_hit2", 1, 3, 1, 0, 1, 0, 0);
        repeat (6) cyc(0, 0, 0, 1);
        check("l_inv2_end", 1, 3, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0); check("l_hit3", 1, 3, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0); check("l_over_hit", 1, 3, 0, 1, 0, 1, 0);

        // Last life lost on the same cycle as the final countdown wrap.
        cyc(1, 0, 0, 0); check("w_start", 1, 3, 3, 1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (6) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        repeat (6) cyc(0, 0, 0, 1);
        repeat (33) cyc(0, 0, 0, 0);
        check("w_before", 1, 1, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0); check("w_hit_wrap", 1, 0, 0, 1, 0, 1, 1);

        // Reset mid-invulnerability, IDLE ignores hits, restart from OVER, start beats hit.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0); check("r_hit", 0, 3, 2, 0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        start = 1'b0; hit = 1'b0; frame_start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("r_reset", 0, 3, 3, 1, 0, 0, 0);
        cyc(0, 0, 1, 0); check("r_idle_hit", 0, 3, 3, 1, 0, 0, 0);
        cyc(0, 0, 0, 1); check("r_idle_frame", 0, 3, 3, 1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (12) cyc(0, 0, 0, 0);
        check("r_over", 0, 0, 3, 1, 0, 1, 1);
        cyc(1, 0, 0, 0); check("r_restart", 0, 3, 3, 1, 0, 0, 0);
        cyc(1, 0, 1, 0); check("r_start_hit", 0, 3, 3, 1, 0, 0, 0);
        cyc(0, 0, 1, 0); check("r_hit_after", 0, 3, 2, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
